// File: rtl/hex8_display.sv
// Eight-digit multiplexed 7-segment driver: scans Disp_data nibbles onto a shared active-low segment bus.
// Latency: Sel/Seg are registered one clock behind the digit index; a Disp_data change shows one clock later.
// Backpressure: none; free-running scan, the input is sampled every clock and never latched.
module hex8_display #(
    parameter int CNT_MAX = 49_999
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] Disp_data,
    output logic [7:0]  Sel,
    output logic [7:0]  Seg
);

    localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(CNT_MAX);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;
    logic          div_wrap;
    logic [3:0]    nibble;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is held off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign div_wrap = (div_cnt_q == CNT_TERM);
    assign nibble   = Disp_data[{idx_q, 2'b00} +: 4];

    always_comb begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + CW'(1);
        idx_d     = div_wrap ? idx_q + 3'd1 : idx_q;
        sel_d     = 8'h01 << idx_q;
        seg_d     = hex_to_seg(nibble);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_q <= '0;
            idx_q     <= 3'd0;
            sel_q     <= 8'h00;
            seg_q     <= 8'hFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
        end
    end

    assign Sel = sel_q;
    assign Seg = seg_q;

endmodule

// File: tb/tb_hex8_display.sv
// Checks two instances (dwell 5 clocks and dwell 1 clock) against a frame-position model of the scan.
module tb_hex8_display;

    localparam int CM_A = 4;
    localparam int CM_B = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_a, data_b, app_a, app_b;
    logic [7:0]  sel_a, seg_a, sel_b, seg_b;
    int          checks = 0;
    int          failures = 0;
    int          n = 0;
    logic [7:0]  codes [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #10 clk = ~clk;

    hex8_display #(.CNT_MAX(CM_A)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .Disp_data(data_a), .Sel(sel_a), .Seg(seg_a));
    hex8_display #(.CNT_MAX(CM_B)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .Disp_data(data_b), .Sel(sel_b), .Seg(seg_b));

    // k = number of clock edges since reset release; digit shown after edge k.
    function automatic int digit_at(int cm, int k);
        return ((k - 1) / (cm + 1)) % 8;
    endfunction

    function automatic logic [7:0] exp_sel(int cm, int k);
        return 8'(1 << digit_at(cm, k));
    endfunction

    function automatic logic [7:0] exp_seg(int cm, int k, logic [31:0] d);
        int i;
        i = digit_at(cm, k);
        return codes[d[i*4 +: 4]];
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        app_a = data_a;
        app_b = data_b;
        if (rst_n) n++; else n = 0;
        @(negedge clk);
        if (rst_n) begin
            check8("sel_a", sel_a, exp_sel(CM_A, n));
            check8("seg_a", seg_a, exp_seg(CM_A, n, app_a));
            check8("sel_b", sel_b, exp_sel(CM_B, n));
            check8("seg_b", seg_b, exp_seg(CM_B, n, app_b));
        end else begin
            check8("rst_sel_a", sel_a, 8'h00);
            check8("rst_seg_a", seg_a, 8'hFF);
            check8("rst_sel_b", sel_b, 8'h00);
            check8("rst_seg_b", seg_b, 8'hFF);
        end
    endtask

    initial begin
        bit found;
        rst_n  = 1'b0;
        data_a = 32'h0;
        data_b = 32'h0;
        repeat (10) step();

        // Release on a falling edge; first rising edge must show digit 0.
        rst_n = 1'b1;
        n = 0;
        step();
        check8("first_sel", sel_a, 8'h01);
        check8("first_seg", seg_a, 8'hC0);

        // Mid-dwell nibble change on digit 0.
        data_a = 32'h0000_000A;
        step();
        check8("middwell_seg", seg_a, 8'h88);
        check8("middwell_sel", sel_a, 8'h01);

        data_a = 32'h1234_5678;
        data_b = 32'h7654_3210;
        repeat (40) step();
        data_b = 32'hFEDC_BA98;
        repeat (16) step();

        repeat (150) begin
            if ($urandom_range(0, 3) == 0) data_a = $urandom;
            if ($urandom_range(0, 3) == 0) data_b = $urandom;
            step();
        end

        // Reset mid-scan while digit 4 is lit.
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (sel_a == 8'h10) found = 1'b1;
            else step();
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL wait_sel10 observed=%h expected=10", sel_a);
        end
        #3 rst_n = 1'b0;
        #1;
        check8("async_sel_a", sel_a, 8'h00);
        check8("async_seg_a", seg_a, 8'hFF);
        check8("async_sel_b", sel_b, 8'h00);
        check8("async_seg_b", seg_b, 8'hFF);
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
